// File: rtl/hub75_fb_arbiter.sv
// Frame-buffer RAM port arbiter: read-out vs write-in ownership via req/gnt/rel,
// read-out priority with bounded write-in starvation and an ownership watchdog.
module hub75_fb_arbiter #(
  parameter int FB_AW      = 13,
  parameter int FB_DW      = 16,
  parameter int MAX_RD_RUN = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rd_req,
  output logic             o_rd_gnt,
  input  logic             i_rd_rel,
  input  logic [FB_AW-1:0] i_rd_addr,
  input  logic             i_rd_ren,
  input  logic             i_wi_req,
  output logic             o_wi_gnt,
  input  logic             i_wi_rel,
  input  logic [FB_AW-1:0] i_wi_addr,
  input  logic [FB_DW-1:0] i_wi_data,
  input  logic             i_wi_wren,
  output logic [FB_AW-1:0] o_fb_addr,
  output logic [FB_DW-1:0] o_fb_wdata,
  output logic             o_fb_wren,
  output logic             o_fb_rden,
  output logic             o_err_timeout,
  output logic             o_err_owner
);

  localparam int RCW = $clog2(MAX_RD_RUN + 1);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RCW-1:0] RUN_MAX = RCW'(MAX_RD_RUN);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN_RD, S_OWN_WI} state_t;

  state_t         r_state, w_next;
  logic [RCW-1:0] r_run_cnt;
  logic [WDW-1:0] r_wd_cnt;
  logic           r_rd_gnt, r_wi_gnt, r_err_timeout, r_err_owner;
  logic           w_grant_rd, w_grant_wi, w_wd_hit, w_wd_fire;

  assign w_wd_hit = (TIMEOUT > 0) && (r_wd_cnt == WD_LAST);

  always_comb begin
    w_next     = r_state;
    w_grant_rd = 1'b0;
    w_grant_wi = 1'b0;
    w_wd_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Write-in only wins a contested cycle once read-out has used its run budget.
        if (i_rd_req && (!i_wi_req || (r_run_cnt != RUN_MAX))) begin
          w_grant_rd = 1'b1;
          w_next     = S_OWN_RD;
        end else if (i_wi_req) begin
          w_grant_wi = 1'b1;
          w_next     = S_OWN_WI;
        end
      end
      S_TURN: w_next = S_IDLE;
      S_OWN_RD: begin
        if (i_rd_rel) begin
          w_next = S_TURN;
        end else if (w_wd_hit) begin
          w_next    = S_TURN;
          w_wd_fire = 1'b1;
        end
      end
      S_OWN_WI: begin
        if (i_wi_rel) begin
          w_next = S_TURN;
        end else if (w_wd_hit) begin
          w_next    = S_TURN;
          w_wd_fire = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_rd_gnt      <= 1'b0;
      r_wi_gnt      <= 1'b0;
      r_run_cnt     <= '0;
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
      r_err_owner   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rd_gnt <= w_grant_rd;
      r_wi_gnt <= w_grant_wi;

      if (w_grant_rd) begin
        if (!i_wi_req)
          r_run_cnt <= '0;
        else if (r_run_cnt != RUN_MAX)
          r_run_cnt <= r_run_cnt + 1'b1;
      end else if (w_grant_wi) begin
        r_run_cnt <= '0;
      end

      if (w_grant_rd || w_grant_wi)
        r_wd_cnt <= '0;
      else if ((r_state == S_OWN_RD) || (r_state == S_OWN_WI))
        r_wd_cnt <= r_wd_cnt + 1'b1;

      if (w_wd_fire) begin
        r_err_timeout <= 1'b1;
        r_err_owner   <= (r_state == S_OWN_WI);
      end
    end
  end

  always_comb begin
    o_fb_addr  = '0;
    o_fb_wdata = '0;
    o_fb_wren  = 1'b0;
    o_fb_rden  = 1'b0;
    case (r_state)
      S_OWN_RD: begin
        o_fb_addr = i_rd_addr;
        o_fb_rden = i_rd_ren;
      end
      S_OWN_WI: begin
        o_fb_addr  = i_wi_addr;
        o_fb_wdata = i_wi_data;
        o_fb_wren  = i_wi_wren;
      end
      default: ;
    endcase
  end

  assign o_rd_gnt      = r_rd_gnt;
  assign o_wi_gnt      = r_wi_gnt;
  assign o_err_timeout = r_err_timeout;
  assign o_err_owner   = r_err_owner;

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Directed self-checking bench for hub75_fb_arbiter (MAX_RD_RUN=4, TIMEOUT=16).
module tb_hub75_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, rd_rel, rd_ren, rd_gnt;
  logic [12:0] rd_addr;
  logic        wi_req, wi_rel, wi_wren, wi_gnt;
  logic [12:0] wi_addr;
  logic [15:0] wi_data;
  logic [12:0] fb_addr;
  logic [15:0] fb_wdata;
  logic        fb_wren, fb_rden, err_timeout, err_owner;

  int tests = 0;
  int fails = 0;

  hub75_fb_arbiter #(.FB_AW(13), .FB_DW(16), .MAX_RD_RUN(4), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_req(rd_req), .o_rd_gnt(rd_gnt), .i_rd_rel(rd_rel),
    .i_rd_addr(rd_addr), .i_rd_ren(rd_ren),
    .i_wi_req(wi_req), .o_wi_gnt(wi_gnt), .i_wi_rel(wi_rel),
    .i_wi_addr(wi_addr), .i_wi_data(wi_data), .i_wi_wren(wi_wren),
    .o_fb_addr(fb_addr), .o_fb_wdata(fb_wdata), .o_fb_wren(fb_wren),
    .o_fb_rden(fb_rden), .o_err_timeout(err_timeout), .o_err_owner(err_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int order [6];
  int n, owner, oc, overlap;
  bit done;

  initial begin
    rst = 1'b1;
    rd_req = 0; rd_rel = 0; rd_ren = 1; rd_addr = 13'h0155;
    wi_req = 0; wi_rel = 0; wi_wren = 1; wi_addr = 13'h0022; wi_data = 16'h3333;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_gnt", 32'(rd_gnt), 0);
    chk("rst_wi_gnt", 32'(wi_gnt), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_wdata", 32'(fb_wdata), 0);
    chk("rst_fb_wren", 32'(fb_wren), 0);
    chk("rst_fb_rden", 32'(fb_rden), 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);
    chk("rst_err_owner", 32'(err_owner), 0);
    rst = 1'b0;
    wi_wren = 0;

    // Read-out alone
    step; rd_req = 1; rd_addr = 13'h0123;
    @(negedge clk);
    chk("t1_req_cycle_gnt", 32'(rd_gnt), 0);
    chk("t1_req_cycle_addr", 32'(fb_addr), 0);
    step; rd_req = 0;
    @(negedge clk);
    chk("t1_gnt", 32'(rd_gnt), 1);
    chk("t1_addr_gnt", 32'(fb_addr), 32'h0123);
    chk("t1_rden", 32'(fb_rden), 1);
    chk("t1_wren", 32'(fb_wren), 0);
    step; rd_addr = 13'h0456;
    @(negedge clk);
    chk("t1_gnt_pulse", 32'(rd_gnt), 0);
    chk("t1_addr_own", 32'(fb_addr), 32'h0456);
    step; rd_rel = 1; rd_addr = 13'h0789;
    @(negedge clk);
    chk("t1_addr_rel", 32'(fb_addr), 32'h0789);
    chk("t1_wren_rel", 32'(fb_wren), 0);
    step; rd_rel = 0;
    @(negedge clk);
    chk("t1_turn_addr", 32'(fb_addr), 0);
    chk("t1_turn_rden", 32'(fb_rden), 0);
    step;

    // Write-in owner, stray rd_rel, final write on wi_rel, rel->gnt spacing
    step; wi_req = 1;
    step; wi_req = 0; rd_req = 1; rd_rel = 1;
    wi_addr = 13'h0011; wi_data = 16'h1111; wi_wren = 1;
    @(negedge clk);
    chk("t2_wi_gnt", 32'(wi_gnt), 1);
    chk("t2_wren", 32'(fb_wren), 1);
    chk("t2_addr", 32'(fb_addr), 32'h0011);
    chk("t2_rden", 32'(fb_rden), 0);
    step; rd_rel = 0; wi_rel = 1; wi_addr = 13'h1ABC; wi_data = 16'hBEEF;
    @(negedge clk);
    chk("t2_rel_addr", 32'(fb_addr), 32'h1ABC);
    chk("t2_rel_wren", 32'(fb_wren), 1);
    chk("t2_rel_wdata", 32'(fb_wdata), 32'hBEEF);
    chk("t2_wi_gnt_pulse", 32'(wi_gnt), 0);
    step; wi_rel = 0;
    @(negedge clk);
    chk("t2_turn_wren", 32'(fb_wren), 0);
    chk("t2_rd_gnt_m1", 32'(rd_gnt), 0);
    step;
    @(negedge clk);
    chk("t2_rd_gnt_m2", 32'(rd_gnt), 0);
    step; rd_req = 0; rd_rel = 1;
    @(negedge clk);
    chk("t2_rd_gnt_m3", 32'(rd_gnt), 1);
    chk("t2_rd_rden", 32'(fb_rden), 1);
    chk("t2_rd_wren", 32'(fb_wren), 0);
    step; rd_rel = 0;
    @(negedge clk);
    chk("t2_rel_in_gnt_cycle", 32'(fb_rden), 0);
    step; rd_ren = 0; wi_wren = 0;

    // Both requesting: bounded read-out run
    step; rd_req = 1; wi_req = 1;
    n = 0; owner = 0; oc = 0; overlap = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      step;
      if (rd_gnt && wi_gnt) overlap++;
      if (rd_gnt) begin
        if (n < 6) order[n] = 1;
        n++; owner = 1; oc = 0;
      end else if (wi_gnt) begin
        if (n < 6) order[n] = 2;
        n++; owner = 2; oc = 0;
      end
      if (n >= 6) begin rd_req = 0; wi_req = 0; end
      rd_rel = (owner == 1 && oc == 7);
      wi_rel = (owner == 2 && oc == 2);
      if (owner != 0) begin
        if (rd_rel || wi_rel) owner = 0;
        else oc++;
      end
      @(negedge clk);
      if (fb_wren && fb_rden) overlap++;
      if (n >= 6 && owner == 0 && !rd_rel && !wi_rel) done = 1;
    end
    chk("t3_finished", 32'(done), 1);
    chk("t3_grant0", order[0], 1);
    chk("t3_grant1", order[1], 1);
    chk("t3_grant2", order[2], 1);
    chk("t3_grant3", order[3], 1);
    chk("t3_grant4", order[4], 2);
    chk("t3_grant5", order[5], 1);
    chk("t3_no_overlap", overlap, 0);
    step;

    // Watchdog on a hung write-in owner
    step; wi_req = 1;
    @(negedge clk);
    chk("t4_err_before", 32'(err_timeout), 0);
    step; wi_req = 0; rd_req = 1; wi_wren = 1; wi_addr = 13'h0F0F;
    @(negedge clk);
    chk("t4_wi_gnt", 32'(wi_gnt), 1);
    repeat (15) step;
    @(negedge clk);
    chk("t4_last_owned_wren", 32'(fb_wren), 1);
    chk("t4_last_owned_rd_gnt", 32'(rd_gnt), 0);
    step;
    @(negedge clk);
    chk("t4_turn_wren", 32'(fb_wren), 0);
    chk("t4_err_timeout", 32'(err_timeout), 1);
    chk("t4_err_owner", 32'(err_owner), 1);
    step;
    @(negedge clk);
    chk("t4_idle_rd_gnt", 32'(rd_gnt), 0);
    step; rd_req = 0; rd_ren = 1; rd_addr = 13'h0AAA;
    @(negedge clk);
    chk("t4_rd_gnt", 32'(rd_gnt), 1);
    chk("t4_no_wi_regnt", 32'(wi_gnt), 0);
    chk("t4_rd_addr", 32'(fb_addr), 32'h0AAA);

    // Asynchronous reset while read-out owns
    #2 rst = 1; wi_req = 1;
    #1;
    chk("t5_async_rd_gnt", 32'(rd_gnt), 0);
    chk("t5_async_addr", 32'(fb_addr), 0);
    chk("t5_async_rden", 32'(fb_rden), 0);
    chk("t5_async_err", 32'(err_timeout), 0);
    chk("t5_async_owner", 32'(err_owner), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    step; wi_req = 0; wi_rel = 1;
    @(negedge clk);
    chk("t5_wi_gnt", 32'(wi_gnt), 1);
    chk("t5_rd_gnt", 32'(rd_gnt), 0);
    step; wi_rel = 0;
    @(negedge clk);
    chk("t5_turn_wren", 32'(fb_wren), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
